// File: rtl/bp_pkg.sv
// Shared helpers for the branch-history-table predictor: counter reset value,
// saturating counter arithmetic and PC index extraction.
package bp_pkg;

  // Widest counter and PC the helpers accept; callers cast to their real width.
  localparam int unsigned CTR_MAX_W = 8;
  localparam int unsigned PC_MAX_W  = 32;

  typedef logic [CTR_MAX_W-1:0] ctr_word_t;
  typedef logic [PC_MAX_W-1:0]  pc_word_t;

  // Weakly not-taken: MSB clear, every other bit set.
  function automatic ctr_word_t ctr_reset_val(input int unsigned ctr_w);
    return ctr_word_t'((32'd1 << (ctr_w - 1)) - 32'd1);
  endfunction

  function automatic ctr_word_t ctr_max_val(input int unsigned ctr_w);
    return ctr_word_t'((32'd1 << ctr_w) - 32'd1);
  endfunction

  function automatic ctr_word_t sat_inc(input ctr_word_t v, input int unsigned ctr_w);
    return (v >= ctr_max_val(ctr_w)) ? v : v + ctr_word_t'(1);
  endfunction

  function automatic ctr_word_t sat_dec(input ctr_word_t v);
    return (v == '0) ? v : v - ctr_word_t'(1);
  endfunction

  function automatic int unsigned pc_index(input pc_word_t pc, input int unsigned lsb,
                                           input int unsigned idx_w);
    pc_word_t mask;
    mask = (pc_word_t'(1) << idx_w) - pc_word_t'(1);
    return int'((pc >> lsb) & mask);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One CTR_W-bit saturating direction counter; resets to weakly not-taken.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             upd_en_i,
  input  logic             taken_i,
  output logic [CTR_W-1:0] count_o
);

  logic [CTR_W-1:0] count_q;
  logic [CTR_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (upd_en_i) begin
      if (taken_i) begin
        count_d = CTR_W'(sat_inc(ctr_word_t'(count_q), CTR_W));
      end else begin
        count_d = CTR_W'(sat_dec(ctr_word_t'(count_q)));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= CTR_W'(ctr_reset_val(CTR_W));
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/branch_predictor_bht.sv
// Branch-history-table predictor with registered one-cycle lookup.
// Define BP_BTB_EN to add the tagged target buffer.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned CTR_W     = 2,
  parameter int unsigned INDEX_LSB = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_valid,
  output logic              predict_taken,
  output logic [CTR_W-1:0]  present_state,
  output logic [ADDR_W-1:0] predict_target,
  output logic              btb_hit,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  output logic [15:0]       mispredict_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  // lookup_valid and upd_valid are single-cycle strobes with no back-pressure:
  // one lookup and one update are accepted every cycle, and pred_valid is
  // lookup_valid delayed by exactly one cycle.

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic [CTR_W-1:0] ctr_val [ENTRIES];
  logic [CTR_W-1:0] lk_ctr;
  logic             lk_taken;
  logic             lk_hit;
  logic [ADDR_W-1:0] lk_tgt;

  assign lk_idx = IDX_W'(pc_index(pc_word_t'(lookup_pc), INDEX_LSB, IDX_W));
  assign up_idx = IDX_W'(pc_index(pc_word_t'(upd_pc), INDEX_LSB, IDX_W));

  genvar g;
  generate
    for (g = 0; g < ENTRIES; g++) begin : g_ctr
      logic upd_en;
      assign upd_en = upd_valid && (up_idx == IDX_W'(g));
      bp_sat_counter #(
        .CTR_W(CTR_W)
      ) u_ctr (
        .clk_i   (clk),
        .rst_ni  (reset),
        .upd_en_i(upd_en),
        .taken_i (upd_taken),
        .count_o (ctr_val[g])
      );
    end
  endgenerate

  // Read-before-write: a same-cycle update lands at the edge, so the lookup
  // captures the old counter value with no bypass.
  assign lk_ctr = ctr_val[lk_idx];

`ifdef BP_BTB_EN
  localparam int unsigned TAG_W = ADDR_W - IDX_W - INDEX_LSB;

  logic              btb_valid_q [ENTRIES];
  logic [TAG_W-1:0]  btb_tag_q   [ENTRIES];
  logic [ADDR_W-1:0] btb_tgt_q   [ENTRIES];
  logic [TAG_W-1:0]  lk_tag;
  logic [TAG_W-1:0]  up_tag;

  assign lk_tag = lookup_pc[ADDR_W-1 -: TAG_W];
  assign up_tag = upd_pc[ADDR_W-1 -: TAG_W];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int e = 0; e < int'(ENTRIES); e++) begin
        btb_valid_q[e] <= 1'b0;
      end
    end else if (upd_valid && upd_taken) begin
      btb_valid_q[up_idx] <= 1'b1;
    end
  end

  // Tag and target need no reset; they are qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (reset && upd_valid && upd_taken) begin
      btb_tag_q[up_idx] <= up_tag;
      btb_tgt_q[up_idx] <= upd_target;
    end
  end

  assign lk_hit   = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && lk_ctr[CTR_W-1];
  assign lk_tgt   = lk_hit ? btb_tgt_q[lk_idx] : '0;
`else
  assign lk_hit   = 1'b0;
  assign lk_taken = lk_ctr[CTR_W-1];
  assign lk_tgt   = '0;
`endif

  // PC bits outside the index (and the target in the default build) may be unused.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc, upd_pc, upd_target};

  logic              pred_valid_q;
  logic              taken_q;
  logic [CTR_W-1:0]  state_q;
  logic [ADDR_W-1:0] tgt_q;
  logic              hit_q;
  logic [15:0]       mis_cnt_q;
  logic [15:0]       mis_cnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pred_valid_q <= 1'b0;
      taken_q      <= 1'b0;
      state_q      <= CTR_W'(ctr_reset_val(CTR_W));
      tgt_q        <= '0;
      hit_q        <= 1'b0;
    end else begin
      pred_valid_q <= lookup_valid;
      if (lookup_valid) begin
        taken_q <= lk_taken;
        state_q <= lk_ctr;
        tgt_q   <= lk_tgt;
        hit_q   <= lk_hit;
      end
    end
  end

  always_comb begin
    mis_cnt_d = mis_cnt_q;
    if (upd_valid && upd_mispredict && (mis_cnt_q != 16'hFFFF)) begin
      mis_cnt_d = mis_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mis_cnt_q <= '0;
    end else begin
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign pred_valid     = pred_valid_q;
  assign predict_taken  = taken_q;
  assign present_state  = state_q;
  assign predict_target = tgt_q;
  assign btb_hit        = hit_q;
  assign mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht against a table-of-integers model.
module tb_branch_predictor_bht;

  localparam int ADDR_W    = 16;
  localparam int ENTRIES   = 16;
  localparam int CTR_W     = 2;
  localparam int INDEX_LSB = 0;
  localparam int CTR_TOP   = (1 << CTR_W) - 1;
  localparam int CTR_HALF  = 1 << (CTR_W - 1);
  localparam int PW        = 1 + ADDR_W + 1 + CTR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              lookup_valid;
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_valid;
  logic              predict_taken;
  logic [CTR_W-1:0]  present_state;
  logic [ADDR_W-1:0] predict_target;
  logic              btb_hit;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_mispredict;
  logic [15:0]       mispredict_cnt;

  always #5 clk = ~clk;

  branch_predictor_bht #(
    .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CTR_W(CTR_W), .INDEX_LSB(INDEX_LSB)
  ) dut (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .predict_taken(predict_taken),
    .present_state(present_state), .predict_target(predict_target),
    .btb_hit(btb_hit),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .mispredict_cnt(mispredict_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integer counters plus a target-buffer table.
  int                m_ctr [ENTRIES];
  bit                m_v   [ENTRIES];
  int                m_tag [ENTRIES];
  logic [ADDR_W-1:0] m_tgt [ENTRIES];
  int                m_mis;

  logic              exp_taken;
  logic              exp_hit;
  logic [CTR_W-1:0]  exp_state;
  logic [ADDR_W-1:0] exp_tgt;
  logic [PW-1:0]     exp_q[$];

  function automatic int idx_of(input logic [ADDR_W-1:0] pc);
    return (int'(pc) >> INDEX_LSB) % ENTRIES;
  endfunction

  function automatic int tag_of(input logic [ADDR_W-1:0] pc);
    return int'(pc) / (ENTRIES << INDEX_LSB);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_ctr[i] = CTR_HALF - 1;
      m_v[i]   = 1'b0;
      m_tag[i] = 0;
      m_tgt[i] = '0;
    end
    m_mis = 0;
  endtask

  task automatic predict(input logic [ADDR_W-1:0] pc);
    int i;
    i = idx_of(pc);
    exp_state = CTR_W'(m_ctr[i]);
`ifdef BP_BTB_EN
    exp_hit   = m_v[i] && (m_tag[i] == tag_of(pc));
    exp_taken = exp_hit && (m_ctr[i] >= CTR_HALF);
    exp_tgt   = exp_hit ? m_tgt[i] : '0;
`else
    exp_hit   = 1'b0;
    exp_taken = (m_ctr[i] >= CTR_HALF);
    exp_tgt   = '0;
`endif
  endtask

  task automatic model_update(input logic [ADDR_W-1:0] pc, input bit taken,
                              input logic [ADDR_W-1:0] tgt, input bit misp);
    int i;
    i = idx_of(pc);
    if (taken) begin
      m_ctr[i] = (m_ctr[i] < CTR_TOP) ? m_ctr[i] + 1 : CTR_TOP;
      m_v[i]   = 1'b1;
      m_tag[i] = tag_of(pc);
      m_tgt[i] = tgt;
    end else begin
      m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
    end
    if (misp && m_mis < 65535) m_mis++;
  endtask

  // Drive one cycle from a falling edge; returns at the next falling edge.
  task automatic step(input bit lv, input logic [ADDR_W-1:0] lpc, input bit uv,
                      input logic [ADDR_W-1:0] upc, input bit ut,
                      input logic [ADDR_W-1:0] utgt, input bit um);
    lookup_valid   = lv;
    lookup_pc      = lpc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_target     = utgt;
    upd_mispredict = um;
    if (lv) predict(lpc);
    if (uv) model_update(upc, ut, utgt, um);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    lookup_valid = 1'b0; lookup_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pred_valid got=%0h exp=0", pred_valid); end
    n_checks++; if (present_state !== 2'b01) begin n_fail++; $display("FAIL rst_state got=%0h exp=1", present_state); end
    n_checks++; if (mispredict_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_mis got=%0h exp=0", mispredict_cnt); end
    n_checks++; if ({btb_hit, predict_target, predict_taken} !== '0) begin n_fail++; $display("FAIL rst_outs got=%0h/%0h/%0h exp=0", btb_hit, predict_target, predict_taken); end
    step(1, 16'h0005, 0, '0, 0, '0, 0);
    n_checks++; if (pred_valid !== 1'b1) begin n_fail++; $display("FAIL reset_lookup_valid got=%0h exp=1", pred_valid); end
    n_checks++; if (predict_taken !== exp_taken) begin n_fail++; $display("FAIL reset_lookup_taken got=%0h exp=%0h", predict_taken, exp_taken); end
    n_checks++; if (present_state !== exp_state) begin n_fail++; $display("FAIL reset_lookup_state got=%0h exp=%0h", present_state, exp_state); end
    n_checks++; if (mispredict_cnt !== 16'(m_mis)) begin n_fail++; $display("FAIL reset_lookup_mis got=%0h exp=%0h", mispredict_cnt, m_mis); end
  endtask

  task automatic test_training_alias();
    step(0, '0, 1, 16'h0005, 1, 16'h0100, 0);
    step(0, '0, 1, 16'h0005, 1, 16'h0100, 0);
    step(1, 16'h0005, 0, '0, 0, '0, 0);
    n_checks++; if (present_state !== exp_state || exp_state !== 2'b11) begin n_fail++; $display("FAIL train_state got=%0h exp=%0h", present_state, exp_state); end
    n_checks++; if (predict_taken !== exp_taken) begin n_fail++; $display("FAIL train_taken got=%0h exp=%0h", predict_taken, exp_taken); end
    step(0, '0, 1, 16'h0005, 1, 16'h0100, 0);
    step(1, 16'h0005, 0, '0, 0, '0, 0);
    n_checks++; if (present_state !== exp_state) begin n_fail++; $display("FAIL train_sat_state got=%0h exp=%0h", present_state, exp_state); end
    step(1, 16'h0015, 0, '0, 0, '0, 0);
    n_checks++; if (predict_taken !== exp_taken) begin n_fail++; $display("FAIL alias_taken got=%0h exp=%0h", predict_taken, exp_taken); end
    n_checks++; if (btb_hit !== exp_hit) begin n_fail++; $display("FAIL alias_hit got=%0h exp=%0h", btb_hit, exp_hit); end
  endtask

  task automatic test_collision();
    do_reset();
    step(1, 16'h0003, 1, 16'h0003, 1, 16'h0040, 0);
    n_checks++; if (present_state !== exp_state) begin n_fail++; $display("FAIL collide_same_cycle got=%0h exp=%0h", present_state, exp_state); end
    step(1, 16'h0003, 0, '0, 0, '0, 0);
    n_checks++; if (present_state !== exp_state) begin n_fail++; $display("FAIL collide_next_cycle got=%0h exp=%0h", present_state, exp_state); end
  endtask

  task automatic test_target_buffer();
    step(0, '0, 1, 16'h0042, 1, 16'h1234, 0);
    step(0, '0, 1, 16'h0042, 1, 16'h1234, 0);
    step(1, 16'h0042, 0, '0, 0, '0, 0);
    n_checks++; if (btb_hit !== exp_hit) begin n_fail++; $display("FAIL btb_hit got=%0h exp=%0h", btb_hit, exp_hit); end
    n_checks++; if (predict_taken !== exp_taken) begin n_fail++; $display("FAIL btb_taken got=%0h exp=%0h", predict_taken, exp_taken); end
    n_checks++; if (predict_target !== exp_tgt) begin n_fail++; $display("FAIL btb_target got=%0h exp=%0h", predict_target, exp_tgt); end
    // A not-taken update must leave the stored target alone.
    step(0, '0, 1, 16'h0042, 0, 16'h5555, 0);
    step(1, 16'h0042, 0, '0, 0, '0, 0);
    n_checks++; if (predict_target !== exp_tgt) begin n_fail++; $display("FAIL btb_nt_target got=%0h exp=%0h", predict_target, exp_tgt); end
  endtask

  task automatic test_random();
    logic [PW-1:0] last_obs;
    logic [PW-1:0] obs;
    logic [ADDR_W-1:0] lpc, upc;
    bit lv;
    do_reset();
    last_obs = {1'b0, 16'h0, 1'b0, 2'b01};
    for (int n = 0; n < 400; n++) begin
      lv  = ($urandom_range(0, 3) != 0);
      lpc = ADDR_W'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
      upc = ADDR_W'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
      step(lv, lpc, $urandom_range(0, 1) == 1, upc, $urandom_range(0, 2) != 0,
           ADDR_W'($urandom), $urandom_range(0, 1) == 1);
      if (lv) exp_q.push_back({exp_hit, exp_tgt, exp_taken, exp_state});
      obs = {btb_hit, predict_target, predict_taken, present_state};
      n_checks++; if (pred_valid !== lv) begin n_fail++; $display("FAIL rand_pred_valid cyc=%0d got=%0h exp=%0h", n, pred_valid, lv); end
      if (pred_valid === 1'b1 && exp_q.size() > 0) begin
        last_obs = exp_q.pop_front();
        n_checks++; if (obs !== last_obs) begin n_fail++; $display("FAIL rand_pred cyc=%0d got=%0h exp=%0h", n, obs, last_obs); end
      end else begin
        n_checks++; if (obs !== last_obs) begin n_fail++; $display("FAIL rand_hold cyc=%0d got=%0h exp=%0h", n, obs, last_obs); end
      end
      n_checks++; if (mispredict_cnt !== 16'(m_mis)) begin n_fail++; $display("FAIL rand_mis cyc=%0d got=%0h exp=%0h", n, mispredict_cnt, m_mis); end
    end
    exp_q.delete();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int n = 1; n <= 70000; n++) begin
      step(0, '0, 1, ADDR_W'($urandom), $urandom_range(0, 1) == 1, ADDR_W'($urandom), 1);
      if (n % 10000 == 0 || n == 65535) begin
        n_checks++; if (mispredict_cnt !== 16'(m_mis)) begin n_fail++; $display("FAIL sat_progress n=%0d got=%0h exp=%0h", n, mispredict_cnt, m_mis); end
      end
    end
    n_checks++; if (mispredict_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got=%0h exp=ffff", mispredict_cnt); end
    // upd_mispredict without upd_valid must not count.
    step(0, '0, 0, '0, 0, '0, 1);
    n_checks++; if (mispredict_cnt !== 16'(m_mis)) begin n_fail++; $display("FAIL sat_idle got=%0h exp=%0h", mispredict_cnt, m_mis); end
  endtask

  task automatic test_midrun_reset();
    for (int n = 0; n < 40; n++) begin
      step(1, ADDR_W'($urandom_range(0, 15)), 1, ADDR_W'($urandom_range(0, 15)), 1, ADDR_W'($urandom), 1);
    end
    reset = 1'b0; lookup_valid = 1'b1; lookup_pc = 16'h0005;
    upd_valid = 1'b1; upd_pc = 16'h0005; upd_taken = 1'b1; upd_mispredict = 1'b1;
    @(negedge clk);
    model_reset();
    n_checks++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%0h exp=0", pred_valid); end
    n_checks++; if (present_state !== 2'b01) begin n_fail++; $display("FAIL mid_rst_state got=%0h exp=1", present_state); end
    n_checks++; if (mispredict_cnt !== 16'h0) begin n_fail++; $display("FAIL mid_rst_mis got=%0h exp=0", mispredict_cnt); end
    reset = 1'b1;
    step(0, '0, 0, '0, 0, '0, 0);
    n_checks++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_after got=%0h exp=0", pred_valid); end
    for (int e = 0; e < ENTRIES; e++) begin
      step(1, ADDR_W'(e), 0, '0, 0, '0, 0);
      n_checks++; if (present_state !== exp_state) begin n_fail++; $display("FAIL mid_rst_entry%0d got=%0h exp=%0h", e, present_state, exp_state); end
      n_checks++; if ({btb_hit, predict_taken} !== {exp_hit, exp_taken}) begin n_fail++; $display("FAIL mid_rst_taken%0d got=%0h exp=%0h", e, {btb_hit, predict_taken}, {exp_hit, exp_taken}); end
    end
  endtask

  initial begin
    reset = 1'b0;
    lookup_valid = 1'b0; lookup_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    @(negedge clk);
    test_reset();
    test_training_alias();
    test_collision();
    test_target_buffer();
    test_random();
    test_saturation();
    test_midrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
